// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants for the 32-bit ripple ALU: control codes,
//            datapath width, per-slice mux select codes and a helper that
//            recognises defined control codes.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_W = 32;

  // Operation codes presented on the ALU control input
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Per-slice result mux selects (taken from control[1:0])
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  // True for the five defined operations; reserved codes return 0
  function automatic logic alu_ctrl_valid(input logic [2:0] ctrl);
    logic v;
    v = 1'b0;
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: v = 1'b1;
      default:                                   v = 1'b0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_bit_slice.sv
`default_nettype none
// ============================================================================
// Module   : alu_bit_slice
// Purpose  : One bit of the ripple ALU. Full adder on (a, b ^ binvert) plus
//            a 4:1 result mux selecting AND / OR / adder sum / less.
// Ports    : a, b        - operand bits
//            carryin     - carry from the next-lower slice
//            binvert     - invert b (subtract / compare)
//            less        - value placed on result for the set-less-than op
//            op[1:0]     - result mux select
//            result      - selected result bit
//            carryout    - carry to the next-higher slice
//            set         - raw adder sum bit (used from the MSB slice)
// Revision : 1.0 - initial release
// ============================================================================
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carryin,
  input  logic       binvert,
  input  logic       less,
  input  logic [1:0] op,
  output logic       result,
  output logic       carryout,
  output logic       set
);

  logic w_b;
  logic w_sum;

  assign w_b      = b ^ binvert;
  assign w_sum    = a ^ w_b ^ carryin;
  assign carryout = (a & w_b) | (carryin & (a ^ w_b));
  assign set      = w_sum;

  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = a & w_b;
      OP_OR:   result = a | w_b;
      OP_ADD:  result = w_sum;
      OP_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : 32-bit integer ALU (AND, OR, ADD, SUB, signed SLT) built from a
//            ripple chain of 1-bit slices. All results and flags are
//            registered: one clock of latency, one operation per clock.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset (clears all outputs)
//            dataA     - operand A
//            dataB     - operand B
//            control   - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//            sum       - registered result
//            slt       - registered signed A<B (SLT only)
//            cout      - registered carry-out of bit 31 (ADD/SUB/SLT)
//            overflow  - registered signed overflow (ADD/SUB)
//            zero      - registered result==0 flag
// Revision : 1.0 - initial release
// ============================================================================
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ALU_W-1:0] dataA,
  input  logic [ALU_W-1:0] dataB,
  input  logic [2:0]       control,
  output logic [ALU_W-1:0] sum,
  output logic             slt,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  logic             w_binvert;
  logic [1:0]       w_op;
  // Carry chain kept as an unpacked array so each link is its own net
  logic             w_carry [0:ALU_W];
  logic [ALU_W-1:0] w_result;
  logic             w_set_msb;
  logic [ALU_W-2:0] w_unused_set;
  logic             w_ovf_raw;
  logic             w_less;

  logic [ALU_W-1:0] w_sum_next;
  logic             w_slt_next;
  logic             w_cout_next;
  logic             w_ovf_next;
  logic             w_zero_next;

  logic [ALU_W-1:0] r_sum;
  logic             r_slt;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;

  assign w_binvert  = control[2];
  assign w_op       = control[1:0];
  assign w_carry[0] = w_binvert;

  generate
    for (genvar i = 0; i < ALU_W; i++) begin : g_slice
      if (i == 0) begin : g_lsb
        alu_bit_slice u_slice (
          .a        (dataA[i]),
          .b        (dataB[i]),
          .carryin  (w_carry[i]),
          .binvert  (w_binvert),
          .less     (w_less),
          .op       (w_op),
          .result   (w_result[i]),
          .carryout (w_carry[i+1]),
          .set      (w_unused_set[i])
        );
      end else if (i == ALU_W - 1) begin : g_msb
        alu_bit_slice u_slice (
          .a        (dataA[i]),
          .b        (dataB[i]),
          .carryin  (w_carry[i]),
          .binvert  (w_binvert),
          .less     (1'b0),
          .op       (w_op),
          .result   (w_result[i]),
          .carryout (w_carry[i+1]),
          .set      (w_set_msb)
        );
      end else begin : g_mid
        alu_bit_slice u_slice (
          .a        (dataA[i]),
          .b        (dataB[i]),
          .carryin  (w_carry[i]),
          .binvert  (w_binvert),
          .less     (1'b0),
          .op       (w_op),
          .result   (w_result[i]),
          .carryout (w_carry[i+1]),
          .set      (w_unused_set[i])
        );
      end
    end
  endgenerate

  // Signed overflow: carry into MSB differs from carry out of MSB.
  // XOR-ing it into the sign bit makes the compare correct even when the
  // subtraction itself overflows.
  assign w_ovf_raw = w_carry[ALU_W-1] ^ w_carry[ALU_W];
  assign w_less    = w_set_msb ^ w_ovf_raw;

  // Reserved codes would otherwise leak slice results (e.g. 100 = A & ~B),
  // so the result is masked to zero for anything undefined.
  always_comb begin
    w_sum_next  = '0;
    w_slt_next  = 1'b0;
    w_cout_next = 1'b0;
    w_ovf_next  = 1'b0;
    if (alu_ctrl_valid(control)) begin
      w_sum_next = w_result;
    end
    if (control == ALU_SLT) begin
      w_slt_next = w_less;
    end
    if ((control == ALU_ADD) || (control == ALU_SUB) || (control == ALU_SLT)) begin
      w_cout_next = w_carry[ALU_W];
    end
    if ((control == ALU_ADD) || (control == ALU_SUB)) begin
      w_ovf_next = w_ovf_raw;
    end
    w_zero_next = (w_sum_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum      <= '0;
      r_slt      <= 1'b0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_sum      <= w_sum_next;
      r_slt      <= w_slt_next;
      r_cout     <= w_cout_next;
      r_overflow <= w_ovf_next;
      r_zero     <= w_zero_next;
    end
  end

  assign sum      = r_sum;
  assign slt      = r_slt;
  assign cout     = r_cout;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Self-checking bench for alu. Expected values come from a
//            behavioural model using plain wide/signed arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [2:0]  control;
  logic [31:0] sum;
  logic        slt;
  logic        cout;
  logic        overflow;
  logic        zero;

  logic [35:0] obs;
  int          checks;
  int          failures;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dataA    (dataA),
    .dataB    (dataB),
    .control  (control),
    .sum      (sum),
    .slt      (slt),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  assign obs = {sum, slt, cout, overflow, zero};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {sum, slt, cout, overflow, zero}
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    logic [32:0] t;
    logic [31:0] r;
    logic        s, co, ov;
    r = '0; s = 1'b0; co = 1'b0; ov = 1'b0;
    case (c)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        t  = {1'b0, a} + {1'b0, b};
        r  = t[31:0];
        co = t[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b110: begin
        t  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = t[31:0];
        co = t[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b111: begin
        t  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        co = t[32];
        s  = ($signed(a) < $signed(b));
        r  = {31'd0, s};
      end
      default: r = '0;
    endcase
    return {r, s, co, ov, (r == 32'd0)};
  endfunction

  // Present one operation between edges and wait until just after it is captured
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    @(negedge clk);
    dataA   = a;
    dataB   = b;
    control = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dataA = 32'd20; dataB = 32'd15; control = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 36'd0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", obs, 36'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sum !== 32'd35 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got sum=%h zero=%b exp sum=00000023 zero=0", sum, zero);
    end
  endtask

  task automatic test_add_sub();
    logic [31:0] ta [4] = '{32'd20, 32'd20, 32'd15, 32'd5};
    logic [31:0] tb [4] = '{32'd15, 32'd15, 32'd20, 32'd5};
    logic [2:0]  tc [4] = '{3'b010, 3'b110, 3'b110, 3'b110};
    logic [31:0] ts [4] = '{32'd35, 32'd5, 32'hFFFF_FFFB, 32'd0};
    logic [3:0]  tf [4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0101}; // slt,cout,ovf,zero
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], tb[i], tc[i]);
      checks++;
      if (obs !== {ts[i], tf[i]}) begin
        failures++;
        $display("FAIL add_sub[%0d] got=%h exp=%h", i, obs, {ts[i], tf[i]});
      end
      checks++;
      if (obs !== model(ta[i], tb[i], tc[i])) begin
        failures++;
        $display("FAIL add_sub_model[%0d] got=%h exp=%h", i, obs, model(ta[i], tb[i], tc[i]));
      end
    end
  endtask

  task automatic test_logic();
    logic [31:0] a, b;
    a = 32'hF0F0_F0F0;
    b = 32'hFF00_FF00;
    drive(a, b, 3'b000);
    checks++;
    if (sum !== 32'hF000_F000 || obs !== model(a, b, 3'b000)) begin
      failures++;
      $display("FAIL and got=%h exp=%h", obs, model(a, b, 3'b000));
    end
    drive(a, b, 3'b001);
    checks++;
    if (sum !== 32'hFFF0_FFF0 || obs !== model(a, b, 3'b001)) begin
      failures++;
      $display("FAIL or got=%h exp=%h", obs, model(a, b, 3'b001));
    end
  endtask

  task automatic test_slt();
    logic [31:0] ta [5] = '{32'd20, 32'd15, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] tb [5] = '{32'd15, 32'd20, 32'd1,         32'd1,         32'hFFFF_FFFF};
    logic        te [5] = '{1'b0,   1'b1,   1'b1,          1'b1,          1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(ta[i], tb[i], 3'b111);
      checks++;
      if (sum !== {31'd0, te[i]} || slt !== te[i] || overflow !== 1'b0) begin
        failures++;
        $display("FAIL slt[%0d] got sum=%h slt=%b ovf=%b exp sum=%h slt=%b ovf=0",
                 i, sum, slt, overflow, {31'd0, te[i]}, te[i]);
      end
      checks++;
      if (obs !== model(ta[i], tb[i], 3'b111)) begin
        failures++;
        $display("FAIL slt_model[%0d] got=%h exp=%h", i, obs, model(ta[i], tb[i], 3'b111));
      end
    end
  endtask

  task automatic test_overflow();
    drive(32'h7FFF_FFFF, 32'd1, 3'b010);
    checks++;
    if (sum !== 32'h8000_0000 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_add got sum=%h ovf=%b exp sum=80000000 ovf=1", sum, overflow);
    end
    drive(32'h8000_0000, 32'd1, 3'b110);
    checks++;
    if (sum !== 32'h7FFF_FFFF || overflow !== 1'b1 || cout !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sub got sum=%h ovf=%b cout=%b exp sum=7fffffff ovf=1 cout=1",
               sum, overflow, cout);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  codes [8] = '{3'b010, 3'b101, 3'b110, 3'b000, 3'b011, 3'b111, 3'b100, 3'b001};
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      drive(a, b, codes[i]);
      checks++;
      if (obs !== model(a, b, codes[i])) begin
        failures++;
        $display("FAIL b2b[%0d] ctrl=%b got=%h exp=%h", i, codes[i], obs, model(a, b, codes[i]));
      end
    end
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101);
    checks++;
    if (obs !== {32'd0, 4'b0001}) begin
      failures++;
      $display("FAIL reserved got=%h exp=%h", obs, {32'd0, 4'b0001});
    end
  endtask

  task automatic test_async_reset();
    drive(32'd20, 32'd15, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 36'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs, 36'd0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 36'd0) begin
      failures++;
      $display("FAIL async_reset_hold got=%h exp=%h", obs, 36'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'd5, 32'd5, 3'b110);
    checks++;
    if (obs !== {32'd0, 4'b0101}) begin
      failures++;
      $display("FAIL after_reset got=%h exp=%h", obs, {32'd0, 4'b0101});
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0]  c;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      // Bias some operands toward sign-boundary values
      if ($urandom_range(0, 3) == 0) a = {~a[0], {31{a[0]}}};
      if ($urandom_range(0, 3) == 0) b = {b[1], 30'd0, b[2]};
      c = 3'($urandom_range(0, 7));
      drive(a, b, c);
      checks++;
      if (obs !== model(a, b, c)) begin
        failures++;
        $display("FAIL random[%0d] a=%h b=%h ctrl=%b got=%h exp=%h", i, a, b, c, obs, model(a, b, c));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add_sub();
    test_logic();
    test_slt();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
